// File: rtl/alu_issue.sv
// alu_issue: command queue and issue stage for an external combinational
// shift ALU.
//
// Commands {in_data, in_shift, in_op} are pushed into a DEPTH-entry circular
// FIFO. The FIFO head is presented to the ALU on alu_i/alu_shift/alu_op, and
// the ALU result (alu_o) is captured into a single output register whenever
// that register is empty or being drained this cycle.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   in_valid/in_ready       upstream command handshake
//   in_data/in_shift/in_op  command operand, amount, op
//   alu_i/alu_shift/alu_op  FIFO head driven to the ALU (zero when empty)
//   alu_o                   ALU result for the current alu_* values
//   out_valid/out_ready     downstream result handshake
//   out_data/out_op         captured result and the op that produced it
//   count                   commands waiting in the FIFO
//   stall_cnt               saturating count of back-pressured result cycles
module alu_issue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_data,
  input  logic [3:0]    in_shift,
  input  logic [1:0]    in_op,
  output logic [15:0]   alu_i,
  output logic [3:0]    alu_shift,
  output logic [1:0]    alu_op,
  input  logic [15:0]   alu_o,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_data,
  output logic [1:0]    out_op,
  output logic [CW-1:0] count,
  output logic [7:0]    stall_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry layout: [21:6] data, [5:2] shift, [1:0] op
  logic [21:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [21:0]   head;
  logic          push;
  logic          issue;
  logic          not_empty;

  assign not_empty = (count != '0);
  assign in_ready  = (count != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  // The output register can take a new result when it is empty or when its
  // current contents leave this same edge.
  assign issue     = not_empty && (!out_valid || out_ready);
  assign head      = mem[rd_ptr];

  always_comb begin
    alu_i     = '0;
    alu_shift = '0;
    alu_op    = '0;
    if (not_empty) begin
      alu_i     = head[21:6];
      alu_shift = head[5:2];
      alu_op    = head[1:0];
    end
  end

  // Storage needs no reset: entries are only ever read below count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_data, in_shift, in_op};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (issue) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_data  <= alu_o;
      out_op    <= head[1:0];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 8'hFF)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: emulates the external shift ALU, runs directed
// scenarios plus a randomized phase, and checks every delivered result
// against a scoreboard of expected results queued when commands are accepted.
module tb_alu_issue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_data;
  logic [3:0]    in_shift;
  logic [1:0]    in_op;
  logic [15:0]   alu_i;
  logic [3:0]    alu_shift;
  logic [1:0]    alu_op;
  logic [15:0]   alu_o;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_data;
  logic [1:0]    out_op;
  logic [CW-1:0] count;
  logic [7:0]    stall_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  op;
  } res_t;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  op;
    int          c;
  } got_t;

  res_t exp_q[$];
  got_t got_q[$];

  alu_issue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_op     (in_op),
    .alu_i     (alu_i),
    .alu_shift (alu_shift),
    .alu_op    (alu_op),
    .alu_o     (alu_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op),
    .count     (count),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shift/rotate semantics on a doubled word.
  function automatic logic [15:0] shift_ref(logic [15:0] x, logic [3:0] s, logic [1:0] op);
    logic [31:0] w;
    w = {x, x};
    case (op)
      2'd0: return x << s;
      2'd1: return x >> s;
      2'd2: begin w = w << s; return w[31:16]; end
      default: begin w = w >> s; return w[15:0]; end
    endcase
  endfunction

  assign alu_o = shift_ref(alu_i, alu_shift, alu_op);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: observes what the upcoming rising edge will do.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      chk("occupancy", 32'(count) + 32'(out_valid), 32'(exp_q.size()));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q[0].d));
          chk("out_op", 32'(out_op), 32'(exp_q[0].op));
          if (out_ready) begin
            void'(exp_q.pop_front());
            got_q.push_back('{out_data, out_op, cyc});
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{shift_ref(in_data, in_shift, in_op), in_op});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(logic [15:0] d, logic [3:0] s, logic [1:0] op);
    in_valid = 1'b1;
    in_data  = d;
    in_shift = s;
    in_op    = op;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((count != '0 || out_valid) && n < 30) begin
      step();
      n++;
    end
    if (count != '0 || out_valid) chk("drain_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int base;
    logic [15:0] dv [6];

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    in_op     = '0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_i", 32'(alu_i), 32'd0);
    reset = 1'b0;
    step();

    // Single command latency
    out_ready = 1'b1;
    push_one(16'h8005, 4'd1, 2'd0);
    chk("lat_valid_n", 32'(out_valid), 32'd0);
    chk("lat_alu_i", 32'(alu_i), 32'h8005);
    step();
    chk("lat_valid_n1", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'h000A);
    chk("lat_op", 32'(out_op), 32'd0);
    drain();

    // Four ops back-to-back
    base = got_q.size();
    for (int i = 0; i < 4; i++) push_one(16'h8005, 4'd1, 2'(i));
    drain();
    chk("b2b_n", 32'(got_q.size() - base), 32'd4);
    if (got_q.size() - base == 4) begin
      chk("b2b_r0", 32'(got_q[base].d), 32'h000A);
      chk("b2b_r1", 32'(got_q[base+1].d), 32'h4002);
      chk("b2b_r2", 32'(got_q[base+2].d), 32'h000B);
      chk("b2b_r3", 32'(got_q[base+3].d), 32'hC002);
      for (int i = 1; i < 4; i++)
        chk("b2b_consecutive", 32'(got_q[base+i].c - got_q[base].c), 32'(i));
    end

    // Fill under back-pressure
    out_ready = 1'b0;
    base = got_q.size();
    for (int i = 0; i < 6; i++) dv[i] = 16'h1111 * 16'(i + 1);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = dv[i];
      in_shift = 4'd2;
      in_op    = 2'd2;
      step();
    end
    in_valid = 1'b0;
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    drain();
    chk("full_n", 32'(got_q.size() - base), 32'd5);
    if (got_q.size() - base == 5)
      for (int i = 0; i < 5; i++)
        chk("full_order", 32'(got_q[base+i].d), 32'(shift_ref(dv[i], 4'd2, 2'd2)));
    chk("full_count_end", 32'(count), 32'd0);

    // Simultaneous push and pop at count=2
    out_ready = 1'b0;
    push_one(16'h00F0, 4'd4, 2'd0);
    push_one(16'h0F00, 4'd3, 2'd1);
    push_one(16'hA5A5, 4'd5, 2'd3);
    chk("pp_count_pre", 32'(count), 32'd2);
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    in_shift  = 4'd7;
    in_op     = 2'd2;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("pp_count", 32'(count), 32'd2);
    chk("pp_out_data", 32'(out_data), 32'h01E0);
    drain();

    // Reset with work in flight, then stall saturation
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(16'h0003 + 16'(i), 4'd1, 2'd0);
    chk("mid_count", 32'(count), 32'd3);
    chk("mid_out_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_stall", 32'(stall_cnt), 32'd0);
    chk("mid_rst_alu_i", 32'(alu_i), 32'd0);
    push_one(16'h0001, 4'd15, 2'd0);
    step();
    chk("stall_start", 32'(stall_cnt), 32'd0);
    repeat (10) step();
    chk("stall_10", 32'(stall_cnt), 32'd10);
    repeat (290) step();
    chk("stall_sat", 32'(stall_cnt), 32'd255);
    chk("stall_hold_data", 32'(out_data), 32'h8000);
    drain();
    chk("stall_keep", 32'(stall_cnt), 32'd255);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_data   = 16'($urandom);
      in_shift  = 4'($urandom);
      in_op     = 2'($urandom);
      out_ready = ($urandom_range(0, 9) < 5);
      step();
    end
    drain();
    step();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("end_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: DEPTH, 4, command queue entries (power of two, 2..16).
REQ-002 Parameter: CW, 3, occupancy count width (log2(DEPTH)+1).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream command present.
REQ-006 in_ready  output  1  queue can accept a command this cycle.
REQ-007 in_data  input  16  operand.
REQ-008 in_shift  input  4  shift/rotate amount 0..15.
REQ-009 in_op  input  2  00 shift left, 01 logical shift right, 10 rotate left, 11 rotate right.
REQ-010 alu_i  output  16  operand driven to the combinational shift ALU.
REQ-011 alu_shift  output  4  amount driven to the ALU.
REQ-012 alu_op  output  2  op driven to the ALU.
REQ-013 alu_o  input  16  ALU result for the alu_* values of the same cycle.
REQ-014 out_valid  output  1  registered result available.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 out_data  output  16  captured ALU result.
REQ-017 out_op  output  2  op that produced out_data.
REQ-018 count  output  CW  commands queued (excludes output register).
REQ-019 stall_cnt  output  8  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-020 Command queue SHALL be a DEPTH-entry circular FIFO of {in_data,in_shift,in_op}; read/write pointers wrap DEPTH-1 -> 0.
REQ-021 in_ready SHALL equal (count != DEPTH); no push when full, even if a pop occurs the same cycle.
REQ-022 Push SHALL occur on an edge where in_valid && in_ready.
REQ-023 alu_i/alu_shift/alu_op SHALL combinationally equal the FIFO head when count != 0, else all zero.
REQ-024 issue = (count != 0) && (!out_valid || out_ready); on issue, at the edge: out_data <= alu_o, out_op <= head op, out_valid <= 1, head popped.
REQ-025 If out_valid && out_ready && !issue, out_valid SHALL clear at the edge; out_data/out_op hold their last value.
REQ-026 While out_valid && !out_ready, out_data and out_op SHALL remain stable.
REQ-027 Minimum latency: command pushed at edge N into empty queue with empty output register SHALL show out_valid=1 after edge N+1; sustained throughput one result per cycle.
REQ-028 Simultaneous push and pop SHALL leave count unchanged; results leave in push order.
REQ-029 stall_cnt SHALL increment each cycle out_valid && !out_ready, saturate at 255, and never clear except on reset.

Reset
REQ-030 With reset high at an edge: pointers, count, out_valid, out_data, out_op, stall_cnt SHALL become 0; queued commands and the held result discarded.
REQ-031 During reset cycles in_ready SHALL read 0 is not required; after the first reset edge in_ready SHALL be 1 and alu_* SHALL be 0.
REQ-032 reset SHALL take priority over simultaneous push, issue, or out_ready.

Verification
REQ-033 Reset 2 cycles -> count=0, out_valid=0, out_data=0, stall_cnt=0, in_ready=1, alu_i=0.
REQ-034 Single push 16'h8005/shift 1/op 00, out_ready=1 -> out_valid after edge N+1, out_data=16'h000A, out_op=00.
REQ-035 Push 8005/1 with ops 00,01,10,11 back-to-back, out_ready=1 -> results 000A, 4002, 000B, C002 on consecutive cycles, in order.
REQ-036 out_ready=0, push 6 commands -> 1 in output register, count=4, in_ready=0, 6th not accepted; raise out_ready -> 5 results in order, count returns 0.
REQ-037 count=2, push and out_ready=1 same cycle -> count stays 2, out_data updates to next result.
REQ-038 count=3 with out_valid=1, assert reset one cycle -> count=0, out_valid=0; out_valid=1 held 300 cycles with out_ready=0 -> stall_cnt=255.
